cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 45 ++++
 rtl/cpu_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: run/ROM/flag inputs and PC/RAM/datapath controls.
// The step input exists only when SEQ_STEP_EN is defined.
interface cpu_sequencer_if;
  logic        run;
  logic [7:0]  rom_data;
  logic [1:0]  flags;
`ifdef SEQ_STEP_EN
  logic        step;
`endif
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_value;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [11:0] mem_addr;
  logic        ram_cs;
  logic        ram_we;
  logic        exec_en;
  logic        halted;
  logic [2:0]  state;

`ifdef SEQ_STEP_EN
  modport master (
    input  run, rom_data, flags, step,
    output pc_inc, pc_load, pc_value, instr, oprnd, mem_addr,
           ram_cs, ram_we, exec_en, halted, state
  );
  modport slave (
    output run, rom_data, flags, step,
    input  pc_inc, pc_load, pc_value, instr, oprnd, mem_addr,
           ram_cs, ram_we, exec_en, halted, state
  );
`else
  modport master (
    input  run, rom_data, flags,
    output pc_inc, pc_load, pc_value, instr, oprnd, mem_addr,
           ram_cs, ram_we, exec_en, halted, state
  );
  modport slave (
    output run, rom_data, flags,
    input  pc_inc, pc_load, pc_value, instr, oprnd, mem_addr,
           ram_cs, ram_we, exec_en, halted, state
  );
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for a 4-bit-opcode CPU with Moore, registered outputs.
// Optional single-step input enabled by defining SEQ_STEP_EN.
module cpu_sequencer (
  input  logic                   clk,
  input  logic                   reset,
  cpu_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_JNC  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_LD   = 4'hD;
  localparam logic [3:0] OP_ST   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e      state_q, state_d;
  logic [3:0]  instr_q, instr_d;
  logic [3:0]  oprnd_q, oprnd_d;
  logic [7:0]  addr_lo_q, addr_lo_d;
`ifdef SEQ_STEP_EN
  logic        step_mode_q, step_mode_d;
`endif

  logic        pc_inc_q, pc_inc_d;
  logic        pc_load_q, pc_load_d;
  logic        ram_cs_q, ram_cs_d;
  logic        ram_we_q, ram_we_d;
  logic        exec_en_q, exec_en_d;
  logic        halted_q, halted_d;

  function automatic logic jump_taken(input logic [3:0] op, input logic [1:0] flg);
    logic taken;
    case (op)
      OP_JC:   taken = flg[1];
      OP_JNC:  taken = ~flg[1];
      OP_JZ:   taken = flg[0];
      OP_JNZ:  taken = ~flg[0];
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // State and latched instruction fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      instr_q     <= 4'h0;
      oprnd_q     <= 4'h0;
      addr_lo_q   <= 8'h00;
`ifdef SEQ_STEP_EN
      step_mode_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      oprnd_q     <= oprnd_d;
      addr_lo_q   <= addr_lo_d;
`ifdef SEQ_STEP_EN
      step_mode_q <= step_mode_d;
`endif
    end
  end

  // Next-state and field-latch decode
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    oprnd_d   = oprnd_q;
    addr_lo_d = addr_lo_q;
`ifdef SEQ_STEP_EN
    step_mode_d = step_mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH0;
`ifdef SEQ_STEP_EN
          step_mode_d = 1'b0;
        end else if (bus.step) begin
          state_d     = S_FETCH0;
          step_mode_d = 1'b1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH0: begin
        instr_d = bus.rom_data[7:4];
        oprnd_d = bus.rom_data[3:0];
        if (bus.rom_data[7:4] == OP_HALT) begin
          state_d = S_HALT;
        end else if (bus.rom_data[7] == 1'b1) begin
          state_d = S_FETCH1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_FETCH1: begin
        addr_lo_d = bus.rom_data;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
`ifdef SEQ_STEP_EN
        // A stepped instruction always parks in IDLE afterwards.
        if (bus.run && !step_mode_q) begin
`else
        if (bus.run) begin
`endif
          state_d = S_FETCH0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state; flags are captured on the edge into EXEC
  always_comb begin
    pc_inc_d  = 1'b0;
    pc_load_d = 1'b0;
    ram_cs_d  = 1'b0;
    ram_we_d  = 1'b0;
    exec_en_d = 1'b0;
    halted_d  = 1'b0;
    case (state_d)
      S_FETCH0, S_FETCH1: begin
        pc_inc_d = 1'b1;
      end
      S_EXEC: begin
        exec_en_d = 1'b1;
        pc_load_d = jump_taken(instr_d, bus.flags);
        if ((instr_d == OP_LD) || (instr_d == OP_ST)) begin
          ram_cs_d = 1'b1;
          ram_we_d = (instr_d == OP_ST);
        end else begin
          ram_cs_d = 1'b0;
          ram_we_d = 1'b0;
        end
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        pc_inc_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_inc_q  <= 1'b0;
      pc_load_q <= 1'b0;
      ram_cs_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      exec_en_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pc_inc_q  <= pc_inc_d;
      pc_load_q <= pc_load_d;
      ram_cs_q  <= ram_cs_d;
      ram_we_q  <= ram_we_d;
      exec_en_q <= exec_en_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.pc_inc   = pc_inc_q;
  assign bus.pc_load  = pc_load_q;
  assign bus.pc_value = {oprnd_q, addr_lo_q};
  assign bus.mem_addr = {oprnd_q, addr_lo_q};
  assign bus.instr    = instr_q;
  assign bus.oprnd    = oprnd_q;
  assign bus.ram_cs   = ram_cs_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.exec_en  = exec_en_q;
  assign bus.halted   = halted_q;
  assign bus.state    = state_q;

endmodule
